// File: rtl/io_port.sv
// CPU-facing I/O port: registered transmit word with sticky overrun, plus receive buffer
// (RX_DEPTH-word FIFO when IO_PORT_RX_FIFO_EN is defined, single holding register otherwise).
// Latency: one edge for TX load / RX write; backpressure via TxReady on transmit, RxReady on receive.

module io_port_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign in_rdy  = (count < CW'(DEPTH));
  assign out_vld = (count != '0);
  assign push    = in_vld & in_rdy;
  assign pop     = out_rdy & out_vld;
  // Show-ahead head word; zero while empty so the CPU never sees stale data.
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module io_port #(
  parameter int RX_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IOOut,
  input  logic        IOWrite,
  input  logic        IORead,
  output logic [15:0] IOIn,
  output logic [15:0] TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [15:0] RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        TxBusy,
  output logic        RxAvail,
  output logic        TxOverrun
);
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  tx_state_t tx_state;

  if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_port: RX_DEPTH must be a power of two in 2..16");
  end

  assign TxValid = (tx_state == SEND);
  assign TxBusy  = (tx_state == SEND);

  // A write landing on the handshake edge is still a write while busy: dropped, flagged.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tx_state  <= IDLE;
      TxData    <= 16'h0000;
      TxOverrun <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (IOWrite) begin
            TxData   <= IOOut;
            tx_state <= SEND;
          end
        end
        SEND: begin
          if (IOWrite) TxOverrun <= 1'b1;
          if (TxReady) tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

`ifdef IO_PORT_RX_FIFO_EN
  io_port_fifo #(
    .W     (16),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (CLK),
    .rst_n   (Reset),
    .in_vld  (RxValid),
    .in_dat  (RxData),
    .in_rdy  (RxReady),
    .out_vld (RxAvail),
    .out_dat (IOIn),
    .out_rdy (IORead)
  );
`else
  logic        hold_vld;
  logic [15:0] hold_dat;

  assign RxReady = ~hold_vld;
  assign RxAvail = hold_vld;
  assign IOIn    = hold_vld ? hold_dat : 16'h0000;

  // Push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      hold_vld <= 1'b0;
      hold_dat <= 16'h0000;
    end else if (RxValid && !hold_vld) begin
      hold_vld <= 1'b1;
      hold_dat <= RxData;
    end else if (IORead && hold_vld) begin
      hold_vld <= 1'b0;
    end
  end
`endif
endmodule
